// File: rtl/uart_rx_frame_deser_if.sv
// Bundle of UART RX deserializer strobe, config and result signals.
// master = sampler/sink side driving strobes and config; slave = deserializer.
interface uart_rx_frame_deser_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 4
);
  logic                  deser_en;
  logic                  bit_valid;
  logic                  sampled_bit;
  logic [LEN_WIDTH-1:0]  cfg_data_len;
  logic                  cfg_msb_first;
  logic                  cfg_par_en;
  logic                  cfg_par_type;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;
  logic                  busy;

  modport master (
    output deser_en, bit_valid, sampled_bit,
    output cfg_data_len, cfg_msb_first, cfg_par_en, cfg_par_type,
    input  P_DATA, data_valid, par_err, stp_err, busy
  );

  modport slave (
    input  deser_en, bit_valid, sampled_bit,
    input  cfg_data_len, cfg_msb_first, cfg_par_en, cfg_par_type,
    output P_DATA, data_valid, par_err, stp_err, busy
  );
endinterface

// File: rtl/uart_rx_frame_deser.sv
// Frame-aware UART RX deserializer: start/data/[parity]/stop sequencing per bit strobe.
// Optional parity support is compiled in with macro UART_RX_DESER_PARITY_EN.
module uart_rx_frame_deser #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 4
) (
  input logic                   CLK,
  input logic                   RST,
  uart_rx_frame_deser_if.slave  bus
);

  localparam logic [LEN_WIDTH-1:0] LP_DW  = LEN_WIDTH'(DATA_WIDTH);
  localparam logic [LEN_WIDTH-1:0] LP_MIN = LEN_WIDTH'(5);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [LEN_WIDTH-1:0]  r_cnt;
  logic [LEN_WIDTH-1:0]  r_len;
  logic                  r_msb;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_dv;
  logic                  r_pe;
  logic                  r_se;
  logic                  r_busy;
  logic                  w_stb;
  logic                  w_last_bit;
  logic                  w_go_parity;
  logic                  w_par_mis;
  logic [LEN_WIDTH-1:0]  w_pos;
  logic [DATA_WIDTH-1:0] w_pos_oh;

  // Out-of-range lengths fall back to full width; too-short ones to 5 bits.
  function automatic logic [LEN_WIDTH-1:0] eff_len(input logic [LEN_WIDTH-1:0] len);
    if (len == '0 || len > LP_DW) return LP_DW;
    else if (len < LP_MIN)        return LP_MIN;
    else                          return len;
  endfunction

`ifdef UART_RX_DESER_PARITY_EN
  logic r_par_en;
  logic r_par_type;
  logic r_par_acc;
  logic r_par_mis;
  assign w_go_parity = r_par_en;
  assign w_par_mis   = r_par_mis;
`else
  logic w_unused_par;
  assign w_unused_par = bus.cfg_par_en ^ bus.cfg_par_type;
  assign w_go_parity  = 1'b0;
  assign w_par_mis    = 1'b0;
`endif

  assign w_stb      = bus.deser_en & bus.bit_valid;
  assign w_last_bit = (r_cnt == r_len - 1'b1);
  assign w_pos      = r_msb ? (r_len - 1'b1 - r_cnt) : r_cnt;
  assign w_pos_oh   = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << w_pos;

  always_comb begin
    w_state_nxt = r_state;
    if (!bus.deser_en) begin
      w_state_nxt = S_IDLE;
    end else if (bus.bit_valid) begin
      case (r_state)
        S_IDLE:   if (!bus.sampled_bit) w_state_nxt = S_DATA;
        S_DATA:   if (w_last_bit) w_state_nxt = w_go_parity ? S_PARITY : S_STOP;
        S_PARITY: w_state_nxt = S_STOP;
        S_STOP:   w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  // Frame datapath: config latch, bit capture, parity check, result register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt      <= '0;
      r_len      <= LP_DW;
      r_msb      <= 1'b0;
      r_shift    <= '0;
      r_data     <= '0;
      r_dv       <= 1'b0;
      r_pe       <= 1'b0;
      r_se       <= 1'b0;
`ifdef UART_RX_DESER_PARITY_EN
      r_par_en   <= 1'b0;
      r_par_type <= 1'b0;
      r_par_acc  <= 1'b0;
      r_par_mis  <= 1'b0;
`endif
    end else begin
      r_dv <= 1'b0;
      r_pe <= 1'b0;
      r_se <= 1'b0;
      if (w_stb) begin
        case (r_state)
          S_IDLE: begin
            if (!bus.sampled_bit) begin
              r_cnt      <= '0;
              r_len      <= eff_len(bus.cfg_data_len);
              r_msb      <= bus.cfg_msb_first;
              r_shift    <= '0;
`ifdef UART_RX_DESER_PARITY_EN
              r_par_en   <= bus.cfg_par_en;
              r_par_type <= bus.cfg_par_type;
              r_par_acc  <= 1'b0;
              r_par_mis  <= 1'b0;
`endif
            end
          end
          S_DATA: begin
            if (bus.sampled_bit) r_shift <= r_shift | w_pos_oh;
            r_cnt <= r_cnt + 1'b1;
`ifdef UART_RX_DESER_PARITY_EN
            r_par_acc <= r_par_acc ^ bus.sampled_bit;
`endif
          end
          S_PARITY: begin
`ifdef UART_RX_DESER_PARITY_EN
            r_par_mis <= bus.sampled_bit ^ r_par_acc ^ r_par_type;
`endif
          end
          S_STOP: begin
            r_data <= r_shift;
            r_dv   <= bus.sampled_bit & ~w_par_mis;
            r_pe   <= w_par_mis;
            r_se   <= ~bus.sampled_bit;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.P_DATA     = r_data;
  assign bus.data_valid = r_dv;
  assign bus.par_err    = r_pe;
  assign bus.stp_err    = r_se;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_uart_rx_frame_deser.sv
// Scoreboard bench for uart_rx_frame_deser: frames driven as strobe sequences,
// expected results queued per frame and checked when the result flags pulse.
module tb_uart_rx_frame_deser;
  localparam int DW = 8;
  localparam int LW = 4;
`ifdef UART_RX_DESER_PARITY_EN
  localparam bit PAR_BUILD = 1'b1;
`else
  localparam bit PAR_BUILD = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  uart_rx_frame_deser_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  uart_rx_frame_deser #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          dv;
    logic          pe;
    logic          se;
  } exp_t;

  exp_t          sb_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] last_pdata;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (bus.data_valid || bus.par_err || bus.stp_err) begin
      if (sb_q.size() == 0) begin
        chk_eq("unexpected_flags", {29'd0, bus.data_valid, bus.par_err, bus.stp_err}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk_eq("p_data", {24'd0, bus.P_DATA}, {24'd0, e.data});
        chk_eq("flags_dv_pe_se", {29'd0, bus.data_valid, bus.par_err, bus.stp_err},
               {29'd0, e.dv, e.pe, e.se});
      end
    end
  end

  // Called and returns at posedge+1; gap = idle cycles after the strobe.
  task automatic strobe(input logic b, input int gap);
    bus.bit_valid   = 1'b1;
    bus.sampled_bit = b;
    @(posedge CLK); #1;
    bus.bit_valid   = 1'b0;
    bus.sampled_bit = 1'b1;
    repeat (gap) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic send_frame(input logic [15:0] d, input logic [LW-1:0] len, input logic msb,
                            input logic pen, input logic ptype, input logic pbad,
                            input logic stopb, input int gap);
    int          L;
    logic [15:0] dm;
    logic        par;
    exp_t        e;
    L  = (len == 0 || int'(len) > DW) ? DW : ((len < 5) ? 5 : int'(len));
    dm = d & ((16'd1 << L) - 16'd1);
    bus.cfg_data_len  = len;
    bus.cfg_msb_first = msb;
    bus.cfg_par_en    = pen;
    bus.cfg_par_type  = ptype;
    strobe(1'b0, gap);
    chk_eq("busy_after_start", {31'd0, bus.busy}, 32'd1);
    bus.cfg_data_len  = LW'($urandom);
    bus.cfg_msb_first = 1'($urandom);
    bus.cfg_par_en    = 1'($urandom);
    bus.cfg_par_type  = 1'($urandom);
    for (int k = 0; k < L; k++) strobe(msb ? dm[L-1-k] : dm[k], gap);
    par = (^dm) ^ ptype;
    if (PAR_BUILD && pen) strobe(par ^ pbad, gap);
    e.data = dm[DW-1:0];
    e.pe   = PAR_BUILD && pen && pbad;
    e.se   = ~stopb;
    e.dv   = stopb && !e.pe;
    sb_q.push_back(e);
    last_pdata = e.data;
    chk_eq("busy_before_stop", {31'd0, bus.busy}, 32'd1);
    strobe(stopb, gap);
    chk_eq("busy_after_stop", {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RST               = 1'b1;
    bus.deser_en      = 1'b0;
    bus.bit_valid     = 1'b0;
    bus.sampled_bit   = 1'b1;
    bus.cfg_data_len  = '0;
    bus.cfg_msb_first = 1'b0;
    bus.cfg_par_en    = 1'b0;
    bus.cfg_par_type  = 1'b0;
    last_pdata        = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk_eq("rst_p_data", {24'd0, bus.P_DATA}, 32'd0);
    chk_eq("rst_data_valid", {31'd0, bus.data_valid}, 32'd0);
    chk_eq("rst_par_err", {31'd0, bus.par_err}, 32'd0);
    chk_eq("rst_stp_err", {31'd0, bus.stp_err}, 32'd0);
    chk_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
    RST          = 1'b0;
    bus.deser_en = 1'b1;
    @(posedge CLK); #1;

    // idle-line strobes must not start a frame
    strobe(1'b1, 0);
    strobe(1'b1, 1);
    chk_eq("idle_busy", {31'd0, bus.busy}, 32'd0);

    send_frame(16'h00A5, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    send_frame(16'h0055, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    send_frame(16'h0003, 4'd8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2);
    send_frame(16'h0003, 4'd8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    repeat (4) @(posedge CLK);
    #1;
    chk_eq("hold_p_data", {24'd0, bus.P_DATA}, {24'd0, last_pdata});

    // abort after 4 data bits, including a would-be start strobe while disabled
    bus.cfg_data_len = 4'd8; bus.cfg_msb_first = 1'b0; bus.cfg_par_en = 1'b0;
    strobe(1'b0, 0);
    for (int k = 0; k < 4; k++) strobe(1'b1, 0);
    bus.deser_en    = 1'b0;
    bus.bit_valid   = 1'b1;
    bus.sampled_bit = 1'b0;
    @(posedge CLK); #1;
    bus.bit_valid   = 1'b0;
    bus.sampled_bit = 1'b1;
    chk_eq("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk_eq("abort_p_data", {24'd0, bus.P_DATA}, {24'd0, last_pdata});
    bus.deser_en = 1'b1;
    @(posedge CLK); #1;
    send_frame(16'h003C, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);

    // reset mid-frame, reset wins over a concurrent strobe
    strobe(1'b0, 0);
    strobe(1'b1, 0);
    strobe(1'b0, 0);
    RST             = 1'b1;
    bus.bit_valid   = 1'b1;
    bus.sampled_bit = 1'b1;
    @(posedge CLK); #1;
    bus.bit_valid   = 1'b0;
    chk_eq("midrst_p_data", {24'd0, bus.P_DATA}, 32'd0);
    chk_eq("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk_eq("midrst_flags", {29'd0, bus.data_valid, bus.par_err, bus.stp_err}, 32'd0);
    RST        = 1'b0;
    last_pdata = '0;
    @(posedge CLK); #1;
    send_frame(16'h00FF, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    send_frame(16'h0000, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);

    // length clamping and MSB-first at short lengths
    send_frame(16'h00C3, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    send_frame(16'h003B, 4'd2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    send_frame(16'h01A5, 4'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    send_frame(16'h0016, 4'd5,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0);
    send_frame(16'h00B2, 4'd6,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0);

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) strobe(1'b1, 0);
      send_frame(16'($urandom), LW'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
                 1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0),
                 $urandom_range(0, 2));
    end

    repeat (4) @(posedge CLK);
    #1;
    chk_eq("final_p_data", {24'd0, bus.P_DATA}, {24'd0, last_pdata});
    chk_eq("sb_drain", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_deser.md
# uart_rx_frame_deser

Parametrised UART receive frame deserializer. It sits between the RX bit sampler and the RX data sink. It consumes one sampled bit per strobe and tracks start, data, optional parity and stop bits with an internal FSM. It assembles a runtime-configurable length data word, LSB- or MSB-first, and reports each frame as a valid or error pulse. It replaces the fixed-width shift-only deserializer with a self-sequencing, frame-aware block.

## Interface
Parameters:
- DATA_WIDTH, 8: maximum data bits per frame and width of P_DATA; legal range 5..16.
- LEN_WIDTH, 4: width of cfg_data_len; must satisfy 2^LEN_WIDTH > DATA_WIDTH.

Ports:
- CLK  in  1  block clock; single clock domain.
- RST  in  1  synchronous, active-high reset.
- deser_en  in  1  block enable; low aborts any frame in progress.
- bit_valid  in  1  one-cycle strobe; sampled_bit is valid this cycle.
- sampled_bit  in  1  majority-voted bit value from the sampler.
- cfg_data_len  in  LEN_WIDTH  data bits per frame.
- cfg_msb_first  in  1  0 = LSB-first, 1 = MSB-first.
- cfg_par_en  in  1  1 = frame carries a parity bit.
- cfg_par_type  in  1  0 = even, 1 = odd.
- P_DATA  out  DATA_WIDTH  last completed frame's data word, zero-extended.
- data_valid  out  1  one-cycle pulse: good frame; P_DATA is updated.
- par_err  out  1  one-cycle pulse: parity mismatch.
- stp_err  out  1  one-cycle pulse: stop bit sampled as 0.
- busy  out  1  high while the FSM is not in IDLE.

## Operation
- FSM states: IDLE, DATA, PARITY, STOP. All state changes occur only on a cycle where bit_valid=1 and deser_en=1.
- **IDLE**
  - bit_valid with sampled_bit=0 accepts a start bit and moves to DATA.
  - On acceptance, the cfg_* inputs are latched. Config changes mid-frame are ignored.
  - bit_valid with sampled_bit=1 stays in IDLE.
- **Data length**
  - Effective length L = cfg_data_len.
  - 0 or any value > DATA_WIDTH → L = DATA_WIDTH.
  - 1..4 → L = 5.
- **DATA**
  - Bits are captured into an internal shift register, not into P_DATA.
  - A bit counter runs 0..L-1.
  - LSB-first: bit k goes to position k.
  - MSB-first: bit k goes to position L-1-k.
  - Positions L..DATA_WIDTH-1 are 0.
  - After bit L-1, go to PARITY if the latched par_en=1, else to STOP.
- **PARITY**
  - Expected bit = XOR of the L data bits, inverted when par_type=1.
  - Record the mismatch, then go to STOP.
- **STOP**
  - Shift register → P_DATA, always, even on error.
  - Then pulse the result flags:
    - data_valid=1 when the stop bit is 1 and there is no parity mismatch.
    - Otherwise the relevant error flag(s) pulse instead. par_err and stp_err may pulse together.
  - Return to IDLE.
- **deser_en=0**: FSM forced to IDLE next cycle; partial frame discarded; P_DATA unchanged; no flags pulse.
- **Holding**: P_DATA holds its value between frames.

## Timing
- Reset value of every output is 0. State goes to IDLE and the counter and shift register clear.
- RST mid-frame discards the frame; no flag pulse occurs.
- RST has priority over deser_en, which has priority over bit_valid.
- All outputs are registered. Flags and the P_DATA update appear the cycle after the stop-bit strobe and last exactly one cycle.
- busy rises the cycle after the start strobe and falls the cycle after the stop strobe (same edge as the flags).
- Back-to-back frames are supported: a start strobe is accepted on the cycle immediately after STOP completes. No minimum strobe spacing beyond 1 cycle.
- Frame length in strobes = 1 + L + par_en + 1.

## Configuration
- Macro: UART_RX_DESER_PARITY_EN.
- **Defined**: PARITY state, parity accumulator and par_err are implemented as described above.
- **Undefined**:
  - No PARITY state; DATA goes directly to STOP.
  - cfg_par_en and cfg_par_type ports remain but are ignored.
  - par_err is tied to 0.
  - data_valid depends only on the stop bit.

## Test plan
- 8N1, LSB-first, strobes 0,1,0,1,0,0,1,0,1,1 → P_DATA=0x0A5, data_valid one pulse, no errors, busy high for 10 strobes.
- Len 7, MSB-first, even parity, data 0x55 sent 1,0,1,0,1,0,1, parity 0, stop 1 → P_DATA=0x55, data_valid.
- 8E1 data 0x03 with parity bit 1 (wrong) → P_DATA=0x03, par_err pulse, data_valid stays 0. Repeat with stop=0 → par_err and stp_err pulse in the same cycle.
- deser_en dropped after 4 data bits, re-raised, full 8N1 frame 0x3C sent → first frame discarded, no flags; then P_DATA=0x3C and data_valid.
- RST asserted mid-frame, followed by an immediate back-to-back pair of frames 0xFF, 0x00 (second start strobe on the cycle after the first stop strobe) → outputs 0 after reset; two data_valid pulses with P_DATA=0xFF then 0x00.
- cfg_data_len=0 and cfg_data_len=2 → frames behave as L=DATA_WIDTH and L=5 respectively.
